ped_track: RTL

PED_TRACK -- requirements
Module: ped_track

---
 rtl/chanfpga_pkg.sv | 34 +++
 rtl/ped_accum.sv | 50 +++++
 rtl/ped_track.sv | 137 +++++++++++++
 3 files changed

// File: rtl/chanfpga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chanfpga_pkg
//  Description : Shared channel-FPGA constants, pedestal tracker state
//                encoding and the window-length clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package chanfpga_pkg;

  // Raw ADC sample width used across the channel FPGA
  localparam int c_abits  = 12;
  // Largest log2 averaging window supported by the pedestal tracker
  localparam int c_maxlog = 10;

  // Pedestal tracker states
  typedef logic [1:0] trk_state_t;
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_accum  = 2'd1;
  localparam logic [1:0] c_st_update = 2'd2;
  localparam logic [1:0] c_st_hold   = 2'd3;

  // Limit a requested log2 window to the range [2, maxlog]
  function automatic logic [3:0] clamp_win(input logic [3:0] w, input logic [3:0] maxlog);
    logic [3:0] r;
    r = w;
    if (w < 4'd2)
      r = 4'd2;
    else if (w > maxlog)
      r = maxlog;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ped_accum.sv
`default_nettype none
// ============================================================================
//  Module      : ped_accum
//  Description : Window accumulator and sample counter for the pedestal
//                tracker. done flags the add that completes a 2^n_log window.
//  Revision    : 1.0 - initial release
// ============================================================================
module ped_accum
  import chanfpga_pkg::*;
#(
  parameter int ABITS  = c_abits,
  parameter int MAXLOG = c_maxlog
) (
  input  logic                    adcclk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    add,
  input  logic [ABITS-1:0]        din,
  input  logic [3:0]              n_log,
  output logic                    done,
  output logic [ABITS+MAXLOG-1:0] sum
);

  localparam logic [MAXLOG:0] c_one = {{MAXLOG{1'b0}}, 1'b1};

  logic [ABITS+MAXLOG-1:0] r_sum;
  logic [MAXLOG:0]         r_count;
  logic [MAXLOG:0]         w_last;

  // Index of the final sample in the window (2^n_log - 1)
  assign w_last = (c_one << n_log) - c_one;
  assign done   = add && (r_count == w_last);
  assign sum    = r_sum;

  // Running sum and sample count; clear wins over add
  always_ff @(posedge adcclk or posedge reset) begin
    if (reset) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (add) begin
      r_sum   <= r_sum + {{MAXLOG{1'b0}}, din};
      r_count <= r_count + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ped_track.sv
`default_nettype none
// ============================================================================
//  Module      : ped_track
//  Description : Pedestal tracker and subtractor. Averages the baseline over a
//                2^win_log window while no signal activity is flagged and
//                subtracts the applied pedestal from the ADC stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module ped_track
  import chanfpga_pkg::*;
#(
  parameter int ABITS  = c_abits,
  parameter int MAXLOG = c_maxlog
) (
  input  logic                    adcclk,
  input  logic                    reset,
  input  logic [ABITS-1:0]        adc_data,
  input  logic                    invert,
  input  logic                    auto_mode,
  input  logic [ABITS-1:0]        ped_manual,
  input  logic [3:0]              win_log,
  input  logic                    freeze,
  output logic signed [15:0]      data,
  output logic [ABITS-1:0]        pedestal,
  output logic                    ped_valid
);

  localparam logic [ABITS+MAXLOG-1:0] c_one_sum = {{(ABITS+MAXLOG-1){1'b0}}, 1'b1};

  trk_state_t              r_state;
  logic [3:0]              r_win;
  logic                    r_auto_d;
  logic [ABITS-1:0]        r_adc_d;
  logic                    r_inv_d;

  logic [3:0]              w_win_clamped;
  logic                    w_clear;
  logic                    w_add;
  logic                    w_done;
  logic [ABITS+MAXLOG-1:0] w_sum;
  logic [ABITS+MAXLOG-1:0] w_half;
  logic [ABITS-1:0]        w_new_ped;
  logic signed [ABITS:0]   w_sub;
  logic signed [ABITS:0]   w_res;

  assign w_win_clamped = clamp_win(win_log, 4'(MAXLOG));
  assign w_clear       = (r_state == c_st_idle);
  // A frozen cycle never contributes to the sum, so freeze on the last
  // sample suppresses done as well
  assign w_add         = (r_state == c_st_accum) && !freeze;

  ped_accum #(
    .ABITS  (ABITS),
    .MAXLOG (MAXLOG)
  ) u_accum (
    .adcclk (adcclk),
    .reset  (reset),
    .clear  (w_clear),
    .add    (w_add),
    .din    (adc_data),
    .n_log  (r_win),
    .done   (w_done),
    .sum    (w_sum)
  );

  // Round-to-nearest mean; r_win is always >= 2 so the half-LSB shift is valid
  assign w_half    = c_one_sum << (r_win - 4'd1);
  assign w_new_ped = ABITS'((w_sum + w_half) >> r_win);

  // One bit of headroom makes the difference exact for any sample/pedestal pair
  assign w_sub = $signed({1'b0, r_adc_d}) - $signed({1'b0, pedestal});
  assign w_res = r_inv_d ? -w_sub : w_sub;

  // Two-stage subtract pipeline: register the sample, then subtract and sign-extend
  always_ff @(posedge adcclk or posedge reset) begin
    if (reset) begin
      r_adc_d <= '0;
      r_inv_d <= 1'b0;
      data    <= '0;
    end else begin
      r_adc_d <= adc_data;
      r_inv_d <= invert;
      data    <= 16'(w_res);
    end
  end

  // Previous auto_mode; resets to 1 so coming out of reset in auto mode is not
  // mistaken for a manual-to-auto switch
  always_ff @(posedge adcclk or posedge reset) begin
    if (reset)
      r_auto_d <= 1'b1;
    else
      r_auto_d <= auto_mode;
  end

  // Tracker FSM and pedestal register
  always_ff @(posedge adcclk or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_win     <= 4'd2;
      pedestal  <= '0;
      ped_valid <= 1'b0;
    end else if (!auto_mode) begin
      r_state   <= c_st_idle;
      pedestal  <= ped_manual;
      ped_valid <= 1'b1;
    end else if (!r_auto_d) begin
      // Manual value and valid flag persist until the first tracked update
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_win   <= w_win_clamped;
          r_state <= c_st_accum;
        end
        c_st_accum: begin
          if (freeze)
            r_state <= c_st_hold;
          else if (w_done)
            r_state <= c_st_update;
        end
        c_st_update: begin
          pedestal  <= w_new_ped;
          ped_valid <= 1'b1;
          r_state   <= c_st_idle;
        end
        c_st_hold: begin
          if (!freeze)
            r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
